// File: rtl/glb_bank_mc_pkg.sv
// Shared types and constants for the multi-channel GLB bank.
// Default widths match the standard bank geometry; the top derives its own widths from its parameters.
package glb_bank_mc_pkg;

    localparam int GLB_BANK_ADDR_WIDTH = 17;
    localparam int GLB_BANK_DATA_WIDTH = 64;
    localparam int BANK_BYTE_OFFSET    = $clog2(GLB_BANK_DATA_WIDTH / 8);

    typedef struct packed {
        logic [GLB_BANK_ADDR_WIDTH-1:0]   addr;
        logic [GLB_BANK_DATA_WIDTH-1:0]   data;
        logic [GLB_BANK_DATA_WIDTH/8-1:0] strb;
        logic                             is_wr;
    } glb_bank_mc_req_t;

    function automatic int byte_offset(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/glb_bank_memory.sv
// Single-port bank storage with bit-masked writes.
// Latency: data_out valid RD_LATENCY cycles after ren; writes visible to reads issued the next cycle.
// Backpressure: none, accepts one access per cycle.
module glb_bank_memory #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] bit_sel,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem  [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] pipe [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr] <= (mem[addr] & ~bit_sel) | (data_in & bit_sel);
        end
        if (ren) begin
            pipe[0] <= mem[addr];
        end
        for (int k = 1; k < RD_LATENCY; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end

    assign data_out = pipe[RD_LATENCY-1];

endmodule

// File: rtl/glb_rr_arbiter.sv
// Round-robin single-grant arbiter; search starts at rr_ptr, which moves past each winner.
// Latency: combinational grant, pointer updates on the grant edge.
// Backpressure: grants are forced low while reset is high.
module glb_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] cand;
    logic          found;
    int            sum;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        cand    = '0;
        sum     = 0;
        for (int i = 0; i < N; i++) begin
            sum = int'(rr_ptr) + i;
            if (sum >= N) sum = sum - N;
            cand = IW'(sum);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found && !reset) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/glb_bank_mc.sv
// Multi-channel GLB bank: round-robin shares one single-port memory among write and read-request channels.
// Latency: write lands in the grant cycle; read response MEM_RD_LATENCY+1 cycles after grant, no rsp backpressure.
// Backpressure: valid/ready per channel, one grant per cycle. Optional counters under GLB_BANK_MC_PERF_EN.
module glb_bank_mc
    import glb_bank_mc_pkg::*;
#(
    parameter int NUM_WR_CH       = 2,
    parameter int NUM_RD_CH       = 2,
    parameter int BANK_ADDR_WIDTH = GLB_BANK_ADDR_WIDTH,
    parameter int BANK_DATA_WIDTH = GLB_BANK_DATA_WIDTH,
    parameter int MEM_RD_LATENCY  = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_WR_CH-1:0]                   wr_valid,
    output logic [NUM_WR_CH-1:0]                   wr_ready,
    input  logic [NUM_WR_CH*BANK_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [NUM_WR_CH*BANK_DATA_WIDTH-1:0]   wr_data,
    input  logic [NUM_WR_CH*BANK_DATA_WIDTH/8-1:0] wr_strb,
    input  logic [NUM_RD_CH-1:0]                   rd_valid,
    output logic [NUM_RD_CH-1:0]                   rd_ready,
    input  logic [NUM_RD_CH*BANK_ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD_CH-1:0]                   rd_rsp_valid,
    output logic [BANK_DATA_WIDTH-1:0]             rd_rsp_data
`ifdef GLB_BANK_MC_PERF_EN
    ,
    output logic [31:0]                            stall_cnt,
    output logic [31:0]                            op_cnt
`endif
);

    localparam int N   = NUM_WR_CH + NUM_RD_CH;
    localparam int IW  = $clog2(N);
    localparam int AW  = BANK_ADDR_WIDTH;
    localparam int DW  = BANK_DATA_WIDTH;
    localparam int SW  = DW / 8;
    localparam int OFF = byte_offset(DW);
    localparam int WAW = AW - OFF;

    typedef struct packed {
        logic [WAW-1:0] addr;
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
        logic           is_wr;
    } req_t;

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    req_t          sel;
    logic [DW-1:0] bit_sel;
    logic [DW-1:0] mem_dout;
    logic          addr_lsb_unused;

    assign req      = {rd_valid, wr_valid};
    assign gnt_any  = |gnt;
    assign wr_ready = gnt[NUM_WR_CH-1:0];
    assign rd_ready = gnt[N-1:NUM_WR_CH];
    // Byte offset bits never reach the memory.
    assign addr_lsb_unused = ^{wr_addr, rd_addr};

    glb_rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_WR_CH; i++) begin
            if (gnt_any && int'(gnt_idx) == i) begin
                sel.addr  = wr_addr[i*AW+OFF +: WAW];
                sel.data  = wr_data[i*DW +: DW];
                sel.strb  = wr_strb[i*SW +: SW];
                sel.is_wr = 1'b1;
            end
        end
        for (int j = 0; j < NUM_RD_CH; j++) begin
            if (gnt_any && int'(gnt_idx) == NUM_WR_CH + j) begin
                sel.addr = rd_addr[j*AW+OFF +: WAW];
            end
        end
    end

    always_comb begin
        bit_sel = '0;
        for (int b = 0; b < SW; b++) begin
            bit_sel[b*8 +: 8] = {8{sel.strb[b]}};
        end
    end

    glb_bank_memory #(
        .ADDR_WIDTH (WAW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (MEM_RD_LATENCY)
    ) u_mem (
        .clk      (clk),
        .wen      (gnt_any & sel.is_wr),
        .ren      (gnt_any & ~sel.is_wr),
        .addr     (sel.addr),
        .data_in  (sel.data),
        .bit_sel  (bit_sel),
        .data_out (mem_dout)
    );

    // One-hot channel vector per stage doubles as the in-flight valid.
    logic [NUM_RD_CH-1:0] trk [MEM_RD_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MEM_RD_LATENCY; k++) trk[k] <= '0;
            rd_rsp_valid <= '0;
            rd_rsp_data  <= '0;
        end else begin
            trk[0] <= gnt[N-1:NUM_WR_CH];
            for (int k = 1; k < MEM_RD_LATENCY; k++) trk[k] <= trk[k-1];
            rd_rsp_valid <= trk[MEM_RD_LATENCY-1];
            if (|trk[MEM_RD_LATENCY-1]) rd_rsp_data <= mem_dout;
        end
    end

`ifdef GLB_BANK_MC_PERF_EN
    logic multi_req;
    logic stall_evt;

    assign multi_req = |(req & (req - N'(1)));
    assign stall_evt = (|req & ~gnt_any) | multi_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            op_cnt    <= '0;
        end else begin
            if (stall_evt && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
            if (gnt_any && op_cnt != 32'hFFFF_FFFF)      op_cnt    <= op_cnt + 32'd1;
        end
    end
`endif

endmodule
